// File: rtl/result_tx_shifter.sv
// Captures a finished search result and shifts it out as a framed sequence of words
// (header, nonce, optional hash words) over a valid/ready handshake.
module result_tx_shifter #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned HASH_WORDS = 8,
  parameter logic [15:0] SYNC_TAG   = 16'hB17C
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         load,
  input  logic                         abort,
  input  logic                         found,
  input  logic [WORD_W-1:0]            nonce,
  input  logic [HASH_WORDS*WORD_W-1:0] hash,
  output logic [WORD_W-1:0]            tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy,
  output logic                         tx_done,
  output logic [3:0]                   words_sent
);

  localparam int unsigned HASH_W = HASH_WORDS * WORD_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   lenm1_q, lenm1_d;
  logic [CNT_W-1:0]   words_sent_q, words_sent_d;
  logic [WORD_W-1:0]  nonce_q, nonce_d;
  logic [HASH_W-1:0]  hash_q, hash_d;
  logic [WORD_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               tx_done_q, tx_done_d;

  logic               xfer_c;
  logic               last_c;
  logic [CNT_W-1:0]   len_m1_c;
  logic [WORD_W-1:0]  header_c;

  assign xfer_c   = tx_valid_q & tx_ready;
  assign last_c   = (idx_q == lenm1_q);
  assign len_m1_c = found ? CNT_W'(HASH_WORDS + 1) : CNT_W'(1);
  assign header_c = WORD_W'({SYNC_TAG, 11'd0, len_m1_c, found});

  // State register and registered datapath/outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      lenm1_q      <= '0;
      words_sent_q <= '0;
      nonce_q      <= '0;
      hash_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lenm1_q      <= lenm1_d;
      words_sent_q <= words_sent_d;
      nonce_q      <= nonce_d;
      hash_q       <= hash_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
    end
  end

  // Next-state logic; abort always wins
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load && !abort) state_d = SEND;
      SEND: begin
        if (abort)                 state_d = IDLE;
        else if (xfer_c && last_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; hash words leave from the top of a left-shifting register
  always_comb begin
    idx_d        = idx_q;
    lenm1_d      = lenm1_q;
    words_sent_d = words_sent_q;
    nonce_d      = nonce_q;
    hash_d       = hash_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
    tx_done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load && !abort) begin
          nonce_d      = nonce;
          hash_d       = hash;
          lenm1_d      = len_m1_c;
          idx_d        = '0;
          words_sent_d = '0;
          tx_data_d    = header_c;
          tx_valid_d   = 1'b1;
          busy_d       = 1'b1;
        end
      end
      SEND: begin
        if (xfer_c) words_sent_d = words_sent_q + CNT_W'(1);
        if (abort || (xfer_c && last_c)) begin
          tx_data_d  = '0;
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          tx_done_d  = !abort;
        end else if (xfer_c) begin
          idx_d     = idx_q + CNT_W'(1);
          hash_d    = (idx_q >= CNT_W'(2)) ? (hash_q << WORD_W) : hash_q;
          tx_data_d = (idx_q == '0) ? nonce_q : hash_d[HASH_W-1 -: WORD_W];
        end
      end
      DONE: begin
        busy_d = 1'b0;
      end
      default: begin
        tx_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;
  assign words_sent = words_sent_q;

endmodule
